// File: rtl/oddeven_run_ctrl_pkg.sv
// Shared types and constants for the odd/even counter run sequencer.
package oddeven_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    localparam int START_EVEN = 0;
    localparam int START_ODD  = 1;

    // Timer width large enough to hold the longer of the two phase lengths.
    function automatic int timer_width(input int clear_cycles, input int max_run);
        int longest;
        longest = (max_run > clear_cycles) ? max_run : clear_cycles;
        return (longest < 2) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/oddeven_phase_timer.sv
// Loadable down-counter shared by the clear hold and the run timeout.
module oddeven_phase_timer #(
    parameter int TW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          expired
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/oddeven_run_ctrl.sv
// Sequencer that clears, releases and watches an odd/even step counter
// until its count reaches a target, with an optional opposite-parity phase.
module oddeven_run_ctrl
    import oddeven_run_ctrl_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int MAX_RUN      = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic             cmd_alt,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             abort,
    output logic             cnt_reset,
    output logic             cnt_mode,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int TW = timer_width(CLEAR_CYCLES, MAX_RUN);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic             alt_q, alt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             cnt_mode_q, cnt_mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic          hit;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_en;
    logic          tmr_expired;

    assign hit = (cnt_value >= target_q);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        alt_d      = alt_q;
        phase_d    = phase_q;
        target_d   = target_q;
        cnt_mode_d = cnt_mode_q;
        err_d      = err_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d     = cmd_mode;
                    alt_d      = cmd_alt;
                    target_d   = cmd_target;
                    phase_d    = 1'b0;
                    cnt_mode_d = cmd_mode;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    err_d    = 1'b1;
                    result_d = cnt_value;
                    state_d  = ST_FINISH;
                end else if (tmr_expired) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort takes priority; a hit beats a same-cycle timeout.
                if (abort) begin
                    err_d    = 1'b1;
                    result_d = cnt_value;
                    state_d  = ST_FINISH;
                end else if (hit) begin
                    if (alt_q && !phase_q) begin
                        phase_d    = 1'b1;
                        cnt_mode_d = ~mode_q;
                        state_d    = ST_CLEAR;
                    end else begin
                        err_d    = 1'b0;
                        result_d = cnt_value;
                        state_d  = ST_FINISH;
                    end
                end else if (tmr_expired) begin
                    err_d    = 1'b1;
                    result_d = cnt_value;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered against the next state so they line up with it.
        cnt_reset_d = (state_d != ST_RUN);
        done_d      = (state_d == ST_FINISH);
    end

    assign tmr_load = ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) ||
                      ((state_d == ST_RUN)   && (state_q != ST_RUN));
    assign tmr_load_val = (state_d == ST_CLEAR) ? TW'(CLEAR_CYCLES - 1) : TW'(MAX_RUN - 1);
    assign tmr_en = (state_q == ST_CLEAR) || (state_q == ST_RUN);

    oddeven_phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_EVEN;
            alt_q       <= 1'b0;
            phase_q     <= 1'b0;
            target_q    <= '0;
            cnt_reset_q <= 1'b1;
            cnt_mode_q  <= MODE_EVEN;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            alt_q       <= alt_d;
            phase_q     <= phase_d;
            target_q    <= target_d;
            cnt_reset_q <= cnt_reset_d;
            cnt_mode_q  <= cnt_mode_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cnt_reset = cnt_reset_q;
    assign cnt_mode  = cnt_mode_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;

endmodule

// File: tb/tb_oddeven_run_ctrl.sv
// Directed bench for oddeven_run_ctrl with a behavioural odd/even counter
// and a scoreboard of expected results per command.
module tb_oddeven_run_ctrl;

    localparam int WIDTH   = 16;
    localparam int CLR     = 2;
    localparam int MAX_RUN = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_mode = 1'b0;
    logic             cmd_alt = 1'b0;
    logic [WIDTH-1:0] cmd_target = '0;
    logic             abort = 1'b0;
    logic             cnt_reset;
    logic             cnt_mode;
    logic [WIDTH-1:0] cnt_value = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             er;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Counter model: holds its start value while reset, else steps by 2 and wraps.
    always @(posedge clk) begin
        if (cnt_reset)
            cnt_value <= {{(WIDTH-1){1'b0}}, cnt_mode};
        else
            cnt_value <= cnt_value + 16'd2;
    end

    oddeven_run_ctrl #(
        .WIDTH        (WIDTH),
        .CLEAR_CYCLES (CLR),
        .MAX_RUN      (MAX_RUN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_alt    (cmd_alt),
        .cmd_target (cmd_target),
        .abort      (abort),
        .cnt_reset  (cnt_reset),
        .cnt_mode   (cnt_mode),
        .cnt_value  (cnt_value),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input string tag, input logic m, input logic a,
                         input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] er_res,
                         input logic er_err, input int lat);
        exp_t e;
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_alt    = a;
        cmd_target = t;
        e.res = er_res;
        e.er  = er_err;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // n0 = negedges already consumed since acceptance.
    task automatic wait_done(input string tag, input int n0);
        exp_t e;
        int   n;
        bit   seen;
        n    = n0;
        seen = 1'b0;
        e.res = '0;
        e.er  = 1'b0;
        e.lat = 0;
        if (sb.size() > 0) e = sb.pop_front();
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, " done_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, " latency"}, n, e.lat);
            chk({tag, " result"}, result, e.res);
            chk({tag, " err"}, err, e.er);
            @(negedge clk);
            chk({tag, " done_pulse"}, done, 0);
            chk({tag, " idle_after"}, busy, 0);
        end
    endtask

    initial begin
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst cnt_reset", cnt_reset, 1);
        chk("rst cnt_mode", cnt_mode, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        // Even run, target 10: two clear cycles, hit on 6th run cycle.
        issue("even10", 1'b0, 1'b0, 16'd10, 16'd10, 1'b0, CLR + 6 + 1);
        @(negedge clk);
        chk("even10 clr1 cnt_reset", cnt_reset, 1);
        chk("even10 clr1 busy", busy, 1);
        chk("even10 clr1 cnt_mode", cnt_mode, 0);
        @(negedge clk);
        chk("even10 clr2 cnt_reset", cnt_reset, 1);
        @(negedge clk);
        chk("even10 run1 cnt_reset", cnt_reset, 0);
        wait_done("even10", 3);

        // Odd run with even target stops at first value above it.
        issue("odd8", 1'b1, 1'b0, 16'd8, 16'd9, 1'b0, CLR + 5 + 1);
        wait_done("odd8", 0);

        // Ping-pong: odd phase ends at 7, even phase ends at 6.
        issue("pp6", 1'b1, 1'b1, 16'd6, 16'd6, 1'b0, CLR + 4 + CLR + 4 + 1);
        repeat (2) @(negedge clk);
        chk("pp6 phase0 cnt_mode", cnt_mode, 1);
        repeat (5) @(negedge clk);
        chk("pp6 phase1 cnt_mode", cnt_mode, 0);
        chk("pp6 phase1 cnt_reset", cnt_reset, 1);
        wait_done("pp6", 7);

        // Hit on the very cycle the timeout fires: hit wins.
        issue("hit_vs_to", 1'b0, 1'b0, 16'(2 * (MAX_RUN - 1)), 16'(2 * (MAX_RUN - 1)), 1'b0, CLR + MAX_RUN + 1);
        wait_done("hit_vs_to", 0);

        // Timeout after MAX_RUN run cycles.
        issue("timeout", 1'b0, 1'b0, 16'd100, 16'(2 * (MAX_RUN - 1)), 1'b1, CLR + MAX_RUN + 1);
        wait_done("timeout", 0);

        // Odd target in even mode one step beyond the last reachable value.
        issue("timeout_odd_tgt", 1'b0, 1'b0, 16'(2 * (MAX_RUN - 1) + 1), 16'(2 * (MAX_RUN - 1)), 1'b1, CLR + MAX_RUN + 1);
        wait_done("timeout_odd_tgt", 0);

        // Abort on 3rd run cycle, with a command offered while busy.
        issue("abort", 1'b0, 1'b0, 16'd100, 16'd4, 1'b1, 0);
        repeat (5) @(negedge clk);
        chk("abort cmd_ready_busy", cmd_ready, 0);
        chk("abort busy", busy, 1);
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_mode   = 1'b1;
        cmd_target = 16'd3;
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        chk("abort done", done, 1);
        chk("abort result", result, e.res);
        chk("abort err", err, e.er);
        @(negedge clk);
        chk("abort not_queued1", busy, 0);
        @(negedge clk);
        chk("abort not_queued2", busy, 0);

        // Async reset mid-run at count 6; outputs clear without a clock edge.
        issue("areset", 1'b0, 1'b0, 16'd100, 16'd0, 1'b0, 0);
        sb.delete();
        repeat (6) @(negedge clk);
        chk("areset pre busy", busy, 1);
        chk("areset pre cnt", cnt_value, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("areset busy", busy, 0);
        chk("areset cmd_ready", cmd_ready, 1);
        chk("areset cnt_reset", cnt_reset, 1);
        chk("areset cnt_mode", cnt_mode, 0);
        chk("areset done", done, 0);
        chk("areset err", err, 0);
        chk("areset result", result, 0);
        repeat (2) @(negedge clk);
        chk("areset hold done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Target at or below the start value hits on the first run cycle.
        issue("even0", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, CLR + 1 + 1);
        wait_done("even0", 0);
        issue("odd1", 1'b1, 1'b0, 16'd1, 16'd1, 1'b0, CLR + 1 + 1);
        wait_done("odd1", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
